pkt_receiver_mc: RTL and testbench
==================================

Name: pkt_receiver_mc

Overview:
Parametrised, registered successor to the single-output SpiNNaker multicast packet receiver. It buffers incoming packets and optionally checks their parity. Peripheral packets are steered to one of NUM_PER peripheral outputs, selected by routing-key bits. Configuration packets are turned into register-bank writes or diagnostic-counter read replies.

Parameters:
PKT_BITS, 72, full packet width (8 header + 32 key + 32 payload)
NUM_PER, 2, number of peripheral output channels (1..16)
SEL_LSB, 16, lowest key bit of the channel-select field
REG_ADR_BITS, 8, register-bank address width
NUM_DCREGS, 8, number of diagnostic counters readable via reply packets
DCCNT_SEC, 1, address section holding the diagnostic counters
BAD_REG, 32'hdead_beef, value returned for non-existing counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pkt_data_in  in  PKT_BITS  incoming packet
pkt_vld_in  in  1  incoming valid
pkt_rdy_out  out  1  incoming ready
reg_ctr_in  in  32 x NUM_DCREGS  diagnostic counter values
reply_key_in  in  32  base key for reply packets
prx_addr_out  out  REG_ADR_BITS  register write address
prx_wdata_out  out  32  register write data
prx_en_out  out  1  register write strobe, one cycle
dcp_data_out  out  PKT_BITS  diagnostic reply packet
dcp_vld_out  out  1  reply valid
dcp_rdy_in  in  1  reply ready
per_data_out  out  NUM_PER*PKT_BITS  peripheral packets, channel i at [i*PKT_BITS +: PKT_BITS]
per_vld_out  out  NUM_PER  per-channel valid
per_rdy_in  in  NUM_PER  per-channel ready
prx_cnt_out  out  2  [0] peripheral packet dispatched, [1] config packet dispatched
prx_drop_out  out  1  packet dropped (bad parity or bad channel)

Behaviour:
- Reset: all vld outputs 0, prx_en_out 0, prx_cnt_out 0, prx_drop_out 0, FSM IDLE, all data registers 0. pkt_rdy_out is 1 in the first cycle after reset.
- Input stage: a one-entry register (head). pkt_rdy_out = !head_vld || head_dispatch. An accept and a dispatch in the same cycle give full throughput.
- Packet fields:
  - bit 1 = long packet (payload present)
  - bit 4 = config packet
  - key = [39:8]
  - payload = [71:40]
- Channel select: ch = key[SEL_LSB +: max(1,$clog2(NUM_PER))]. When NUM_PER==1, ch is forced to 0.
- Dispatch, at most one head packet per cycle, in order:
  - Peripheral packet, ch < NUM_PER: dispatched when output slice ch is empty or draining this cycle.
  - Peripheral packet, ch >= NUM_PER: dropped immediately.
  - Config write (long packet): always dispatched.
  - Config read (short packet): dispatched per the FSM below.
- Head-of-line blocking is intended: a stalled channel stalls all traffic.
- Peripheral output slices: one-entry registers, one per channel. Latency is 2 cycles from input handshake to per_vld_out. Data must stay stable while vld is high and rdy is low.
- Config write: in the cycle after dispatch, prx_en_out=1 for exactly one cycle, prx_addr_out = key[REG_ADR_BITS-1:0], prx_wdata_out = payload. Address and data hold until the next write.
- Reply FSM, IDLE/REPLY:
  - IDLE, read at head: load the reply register and go to REPLY.
  - REPLY: dcp_vld_out=1.
  - REPLY, dcp_rdy_in=1: if another read is at head, reload and stay in REPLY (back-to-back); otherwise go to IDLE.
  - While REPLY and not draining, a read at head stalls.
- Reply packet:
  - header = {7'b001_1001, pty}
  - key = reply_key_in | offset, where offset = key[REG_ADR_BITS-1:0]
  - payload = reg_ctr_in[reg] if reg<NUM_DCREGS and sec==DCCNT_SEC, else BAD_REG
  - pty = ^key ^ ^payload, giving odd overall parity
  - reg/sec split: low bits are the counter index, upper bits are the section, as in hssl_reg_bank.h
- Counter pulses:
  - prx_cnt_out pulses are combinational, in the dispatch cycle, one bit per packet class.
  - prx_drop_out pulses in the drop cycle.
  - Dropped packets do not pulse prx_cnt_out.
- Reset mid-operation flushes the head, all slices and a pending reply. No partial output is emitted.

Optional Feature:
- PKT_RX_PARITY_CHECK_EN defined: the head packet is dropped (prx_drop_out pulse, no other effect) unless XOR of bits [39:0] (short packet) or [71:0] (long packet) is 1.
- Not defined: parity is ignored and no parity drops occur.

Decomposition:
- Shared package pkt_rx_pkg holds:
  - field bit constants (LNG/CFG/KEY/PLD bit positions)
  - the reply header constant
  - a pkt_fields_t struct
  - a function computing packet parity
- One natural sub-module: pkt_rx_slice, a parametrised one-entry valid/ready register. It is instantiated for the head stage and for each peripheral channel.

Test Plan:
- NUM_PER=4: short packets with key[17:16]=0..3 and all rdy=1 -> each packet appears on its channel after 2 cycles; prx_cnt_out[0] pulses 4 times.
- Hold per_rdy_in[2]=0, send ch2 then ch0 -> ch0 is blocked until per_rdy_in[2] rises; per_data_out[2] stays stable.
- Long config packet with key=0x05, payload=0x12345678 -> one-cycle prx_en_out with addr 0x05 and wdata 0x12345678.
- Read counter 3 of DCCNT_SEC (reg_ctr_in[3]=0xA5) with dcp_rdy_in=0 for 5 cycles, followed by a second read:
  - dcp_data_out holds payload 0xA5 with correct pty
  - the second read stalls, then is issued back-to-back.
- Read a non-existing counter -> reply payload is BAD_REG. NUM_PER=3 with a ch=3 packet -> prx_drop_out pulses and no output valid.
- With PKT_RX_PARITY_CHECK_EN, a packet with even parity -> dropped and counted; a valid packet following it -> delivered normally.

Source files
------------

// File: rtl/pkt_rx_pkg.sv
// Shared definitions for the multicast packet receiver: packet field
// positions, reply header, decoded-field struct, reply FSM states and the
// packet parity helper.
package pkt_rx_pkg;

  localparam int unsigned PKT_W        = 72;
  localparam int unsigned SHORT_W      = 40;
  localparam int unsigned LNG_BIT      = 1;
  localparam int unsigned CFG_BIT      = 4;
  localparam int unsigned KEY_LSB      = 8;
  localparam int unsigned PLD_LSB      = 40;
  // Register address split: low bits index a register, upper bits pick a section
  localparam int unsigned REG_IDX_BITS = 4;

  // Reply header without its parity bit (bit 0)
  localparam logic [6:0] REPLY_HDR = 7'b001_1001;

  typedef struct packed {
    logic        lng;
    logic        cfg;
    logic [7:0]  hdr;
    logic [31:0] key;
    logic [31:0] pld;
  } pkt_fields_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_REPLY = 1'b1
  } reply_state_t;

  function automatic pkt_fields_t pkt_decode(input logic [PKT_W-1:0] pkt);
    pkt_fields_t f;
    f.hdr = pkt[7:0];
    f.lng = pkt[LNG_BIT];
    f.cfg = pkt[CFG_BIT];
    f.key = pkt[KEY_LSB +: 32];
    f.pld = pkt[PLD_LSB +: 32];
    return f;
  endfunction

  // Parity over the bits actually present on the link (payload only if long)
  function automatic logic pkt_parity(input logic [PKT_W-1:0] pkt);
    return pkt[LNG_BIT] ? ^pkt : ^pkt[SHORT_W-1:0];
  endfunction

endpackage

// File: rtl/pkt_receiver_mc_slice.sv
// pkt_rx_slice: one-entry valid/ready register. Accepts when empty or when
// draining in the same cycle; data is held while valid and not ready.
module pkt_rx_slice #(
  parameter int unsigned W = 72
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  output logic [W-1:0] out_data_o,
  output logic         out_vld_o,
  input  logic         out_rdy_i
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  // Next-state: load on accept, clear valid on drain without refill
  always_comb begin
    in_rdy_o = !vld_q || out_rdy_i;
    vld_d    = vld_q;
    data_d   = data_q;
    if (in_rdy_o) begin
      vld_d = in_vld_i;
      if (in_vld_i) data_d = in_data_i;
    end
  end

  // Storage register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld_o  = vld_q;
  assign out_data_o = data_q;

endmodule

// File: rtl/pkt_receiver_mc.sv
// pkt_receiver_mc: buffers multicast packets, steers peripheral packets to
// one of NUM_PER output slices by key bits, turns config packets into
// register writes or diagnostic-counter reply packets.
// Optional: define PKT_RX_PARITY_CHECK_EN to drop packets with even parity.
import pkt_rx_pkg::*;

module pkt_receiver_mc #(
  parameter int unsigned PKT_BITS     = 72,
  parameter int unsigned NUM_PER      = 2,
  parameter int unsigned SEL_LSB      = 16,
  parameter int unsigned REG_ADR_BITS = 8,
  parameter int unsigned NUM_DCREGS   = 8,
  parameter int unsigned DCCNT_SEC    = 1,
  parameter logic [31:0] BAD_REG      = 32'hdead_beef
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PKT_BITS-1:0]         pkt_data_in,
  input  logic                        pkt_vld_in,
  output logic                        pkt_rdy_out,
  input  logic [32*NUM_DCREGS-1:0]    reg_ctr_in,
  input  logic [31:0]                 reply_key_in,
  output logic [REG_ADR_BITS-1:0]     prx_addr_out,
  output logic [31:0]                 prx_wdata_out,
  output logic                        prx_en_out,
  output logic [PKT_BITS-1:0]         dcp_data_out,
  output logic                        dcp_vld_out,
  input  logic                        dcp_rdy_in,
  output logic [NUM_PER*PKT_BITS-1:0] per_data_out,
  output logic [NUM_PER-1:0]          per_vld_out,
  input  logic [NUM_PER-1:0]          per_rdy_in,
  output logic [1:0]                  prx_cnt_out,
  output logic                        prx_drop_out
);

  localparam int unsigned CH_BITS  = (NUM_PER > 1) ? $clog2(NUM_PER) : 1;
  localparam int unsigned SEC_BITS = REG_ADR_BITS - REG_IDX_BITS;

  logic [PKT_BITS-1:0]     head_data;
  logic                    head_vld, head_disp;
  pkt_fields_t             hf;
  logic [CH_BITS-1:0]      ch;
  logic                    ch_ok, ch_rdy, par_ok;
  logic [NUM_PER-1:0]      per_in_rdy, per_in_vld;
  logic                    per_disp, wr_disp, rd_disp, drop;
  logic [REG_ADR_BITS-1:0] offset;
  logic [31:0]             rpl_key, rpl_pld;
  logic [PKT_BITS-1:0]     rpl_pkt;
  reply_state_t            state_q, state_d;
  logic [PKT_BITS-1:0]     reply_q, reply_d;
  logic [REG_ADR_BITS-1:0] addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    en_q;
  logic                    unused_fields;

  pkt_rx_slice #(.W(PKT_BITS)) u_head (
    .clk        (clk),
    .reset      (reset),
    .in_data_i  (pkt_data_in),
    .in_vld_i   (pkt_vld_in),
    .in_rdy_o   (pkt_rdy_out),
    .out_data_o (head_data),
    .out_vld_o  (head_vld),
    .out_rdy_i  (head_disp)
  );

`ifdef PKT_RX_PARITY_CHECK_EN
  assign par_ok = pkt_parity(head_data);
`else
  assign par_ok = 1'b1;
`endif

  assign unused_fields = ^{hf.hdr, hf.key};

  // Decode head packet and resolve the target channel's readiness
  always_comb begin
    hf     = pkt_decode(head_data);
    ch     = '0;
    if (NUM_PER > 1) ch = hf.key[SEL_LSB +: CH_BITS];
    ch_ok  = 1'b0;
    ch_rdy = 1'b0;
    for (int unsigned i = 0; i < NUM_PER; i++) begin
      if (ch == CH_BITS'(i)) begin
        ch_ok  = 1'b1;
        ch_rdy = per_in_rdy[i];
      end
    end
  end

  // Dispatch decision for the head packet; at most one class fires per cycle
  always_comb begin
    per_disp = 1'b0;
    wr_disp  = 1'b0;
    rd_disp  = 1'b0;
    drop     = 1'b0;
    if (head_vld && !reset) begin
      if (!par_ok)        drop     = 1'b1;
      else if (!hf.cfg) begin
        if (!ch_ok)       drop     = 1'b1;
        else              per_disp = ch_rdy;
      end
      else if (hf.lng)    wr_disp  = 1'b1;
      else                rd_disp  = (state_q == ST_IDLE) || dcp_rdy_in;
    end
    head_disp = drop || per_disp || wr_disp || rd_disp;
  end

  for (genvar g = 0; g < NUM_PER; g++) begin : g_per
    assign per_in_vld[g] = per_disp && (ch == CH_BITS'(g));

    pkt_rx_slice #(.W(PKT_BITS)) u_slice (
      .clk        (clk),
      .reset      (reset),
      .in_data_i  (head_data),
      .in_vld_i   (per_in_vld[g]),
      .in_rdy_o   (per_in_rdy[g]),
      .out_data_o (per_data_out[g*PKT_BITS +: PKT_BITS]),
      .out_vld_o  (per_vld_out[g]),
      .out_rdy_i  (per_rdy_in[g])
    );
  end

  // Reply packet formed from the read offset; missing counters read BAD_REG
  always_comb begin
    offset  = hf.key[REG_ADR_BITS-1:0];
    rpl_pld = BAD_REG;
    if (offset[REG_ADR_BITS-1:REG_IDX_BITS] == SEC_BITS'(DCCNT_SEC)) begin
      for (int unsigned i = 0; i < NUM_DCREGS; i++) begin
        if (offset[REG_IDX_BITS-1:0] == REG_IDX_BITS'(i)) rpl_pld = reg_ctr_in[32*i +: 32];
      end
    end
    rpl_key = reply_key_in | 32'(offset);
    rpl_pkt = PKT_BITS'({rpl_pld, rpl_key, REPLY_HDR, ^{rpl_key, rpl_pld}});
  end

  // Reply FSM next state; a drain in REPLY may reload back-to-back
  always_comb begin
    state_d = state_q;
    reply_d = reply_q;
    case (state_q)
      ST_IDLE:  if (rd_disp) state_d = ST_REPLY;
      ST_REPLY: if (dcp_rdy_in) state_d = rd_disp ? ST_REPLY : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (rd_disp) reply_d = rpl_pkt;
  end

  // Register-write capture; address and data hold between writes
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (wr_disp) begin
      addr_d  = hf.key[REG_ADR_BITS-1:0];
      wdata_d = hf.pld;
    end
  end

  // State, reply and register-write registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      reply_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      reply_q <= reply_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      en_q    <= wr_disp;
    end
  end

  assign dcp_vld_out   = (state_q == ST_REPLY);
  assign dcp_data_out  = reply_q;
  assign prx_addr_out  = addr_q;
  assign prx_wdata_out = wdata_q;
  assign prx_en_out    = en_q;
  assign prx_cnt_out   = {wr_disp || rd_disp, per_disp};
  assign prx_drop_out  = drop;

endmodule

// File: tb/tb_pkt_receiver_mc.sv
// Scoreboard bench for pkt_receiver_mc with NUM_PER=3: directed scenarios
// followed by randomized traffic checked against a transaction-level model.
module tb_pkt_receiver_mc;

  localparam int NP  = 3;
  localparam int NDC = 8;
  localparam logic [31:0] BAD = 32'hdead_beef;
  typedef logic [71:0] pkt_t;
  typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;

  logic             clk, reset;
  logic [71:0]      pkt_data_in;
  logic             pkt_vld_in, pkt_rdy_out;
  logic [32*NDC-1:0] reg_ctr_in;
  logic [31:0]      reply_key_in;
  logic [7:0]       prx_addr_out;
  logic [31:0]      prx_wdata_out;
  logic             prx_en_out;
  logic [71:0]      dcp_data_out;
  logic             dcp_vld_out, dcp_rdy_in;
  logic [NP*72-1:0] per_data_out;
  logic [NP-1:0]    per_vld_out, per_rdy_in;
  logic [1:0]       prx_cnt_out;
  logic             prx_drop_out;

  pkt_receiver_mc #(
    .PKT_BITS(72), .NUM_PER(NP), .SEL_LSB(16), .REG_ADR_BITS(8),
    .NUM_DCREGS(NDC), .DCCNT_SEC(1), .BAD_REG(BAD)
  ) dut (
    .clk(clk), .reset(reset),
    .pkt_data_in(pkt_data_in), .pkt_vld_in(pkt_vld_in), .pkt_rdy_out(pkt_rdy_out),
    .reg_ctr_in(reg_ctr_in), .reply_key_in(reply_key_in),
    .prx_addr_out(prx_addr_out), .prx_wdata_out(prx_wdata_out), .prx_en_out(prx_en_out),
    .dcp_data_out(dcp_data_out), .dcp_vld_out(dcp_vld_out), .dcp_rdy_in(dcp_rdy_in),
    .per_data_out(per_data_out), .per_vld_out(per_vld_out), .per_rdy_in(per_rdy_in),
    .prx_cnt_out(prx_cnt_out), .prx_drop_out(prx_drop_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  pkt_t exp_per [NP][$];
  wr_t  exp_wr[$];
  pkt_t exp_rep[$];
  int   exp_ev[$];   // 0 peripheral, 1 config, 2 drop
  logic [31:0] ctr [NDC];
  logic mon_en = 1'b0;
  logic rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference behaviour: a packet survives only with odd parity over the bits sent
  function automatic logic model_par_ok(input pkt_t p);
`ifdef PKT_RX_PARITY_CHECK_EN
    return p[1] ? ^p : ^p[39:0];
`else
    return 1'b1;
`endif
  endfunction

  function automatic pkt_t model_reply(input logic [7:0] off);
    logic [31:0] k, d;
    int idx, sec;
    idx = int'(off) % 16;
    sec = int'(off) / 16;
    d = (sec == 1 && idx < NDC) ? ctr[idx] : BAD;
    k = reply_key_in | {24'h0, off};
    return {d, k, 7'b0011001, ~^{d, k, 7'b0011001}};
  endfunction

  task automatic model(input pkt_t p);
    logic [31:0] key;
    int ch;
    key = p[39:8];
    ch  = int'(key[17:16]);
    if (!model_par_ok(p)) exp_ev.push_back(2);
    else if (!p[4]) begin
      if (ch >= NP) exp_ev.push_back(2);
      else begin
        exp_ev.push_back(0);
        exp_per[ch].push_back(p);
      end
    end else if (p[1]) begin
      exp_ev.push_back(1);
      exp_wr.push_back({key[7:0], p[71:40]});
    end else begin
      exp_ev.push_back(1);
      exp_rep.push_back(model_reply(key[7:0]));
    end
  endtask

  function automatic pkt_t mkpkt(input logic cfg, input logic lng, input logic [31:0] key,
                                 input logic [31:0] pld, input logic good);
    pkt_t p;
    logic par;
    p = {pld, key, 8'h00};
    p[7:5] = 3'($urandom);
    p[3:2] = 2'($urandom);
    p[4] = cfg;
    p[1] = lng;
    par = lng ? ^p : ^p[39:0];
    p[0] = good ? ~par : par;
    return p;
  endfunction

  function automatic logic [31:0] chkey(input int ch);
    logic [31:0] k;
    k = $urandom;
    k[17:16] = 2'(ch);
    return k;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      per_rdy_in = NP'($urandom);
      dcp_rdy_in = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Must be called just after a rising edge
  task automatic send(input pkt_t p);
    logic acc;
    pkt_data_in = p;
    pkt_vld_in  = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      acc = pkt_rdy_out;
      if (acc) model(p);
      sync();
      if (acc) begin
        pkt_vld_in = 1'b0;
        return;
      end
    end
    pkt_vld_in = 1'b0;
    fail_now("send_timeout");
  endtask

  function automatic logic all_empty();
    logic e;
    e = (exp_ev.size() == 0) && (exp_wr.size() == 0) && (exp_rep.size() == 0);
    for (int i = 0; i < NP; i++) if (exp_per[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain();
    rand_rdy   = 1'b0;
    per_rdy_in = '1;
    dcp_rdy_in = 1'b1;
    for (int n = 0; n < 300 && !all_empty(); n++) sync();
    if (!all_empty()) fail_now("drain_timeout");
    repeat (3) sync();
  endtask

  // Monitor: pops expected outputs on every observed handshake/pulse
  initial begin
    logic        hold [NP];
    logic [71:0] hold_data [NP];
    logic        dhold;
    logic [71:0] dhold_data;
    int          obs;
    for (int i = 0; i < NP; i++) hold[i] = 1'b0;
    dhold = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        for (int i = 0; i < NP; i++) hold[i] = 1'b0;
        dhold = 1'b0;
      end else begin
        for (int i = 0; i < NP; i++) begin
          if (hold[i]) begin
            chk($sformatf("per%0d_hold_vld", i), 80'(per_vld_out[i]), 80'(1));
            chk($sformatf("per%0d_hold_data", i), 80'(per_data_out[i*72 +: 72]), 80'(hold_data[i]));
          end
          if (per_vld_out[i] && per_rdy_in[i]) begin
            if (exp_per[i].size() == 0) fail_now($sformatf("per%0d_unexpected", i));
            else chk($sformatf("per%0d_data", i), 80'(per_data_out[i*72 +: 72]), 80'(exp_per[i].pop_front()));
          end
          hold[i]      = per_vld_out[i] && !per_rdy_in[i];
          hold_data[i] = per_data_out[i*72 +: 72];
        end
        if (dhold) begin
          chk("dcp_hold_vld", 80'(dcp_vld_out), 80'(1));
          chk("dcp_hold_data", 80'(dcp_data_out), 80'(dhold_data));
        end
        if (dcp_vld_out && dcp_rdy_in) begin
          if (exp_rep.size() == 0) fail_now("dcp_unexpected");
          else chk("dcp_data", 80'(dcp_data_out), 80'(exp_rep.pop_front()));
        end
        dhold      = dcp_vld_out && !dcp_rdy_in;
        dhold_data = dcp_data_out;
        if (prx_en_out) begin
          if (exp_wr.size() == 0) fail_now("wr_unexpected");
          else chk("wr_addr_data", 80'({prx_addr_out, prx_wdata_out}), 80'(exp_wr.pop_front()));
        end
        if (prx_cnt_out != 2'b00 || prx_drop_out) begin
          if (prx_cnt_out == 2'b01 && !prx_drop_out)      obs = 0;
          else if (prx_cnt_out == 2'b10 && !prx_drop_out) obs = 1;
          else if (prx_cnt_out == 2'b00 && prx_drop_out)  obs = 2;
          else                                            obs = 9;
          if (exp_ev.size() == 0) fail_now($sformatf("event_unexpected cnt=%b drop=%b", prx_cnt_out, prx_drop_out));
          else chk("event_class", 80'(obs), 80'(exp_ev.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p;
    logic [31:0] k;
    int kind;
    reset        = 1'b1;
    pkt_vld_in   = 1'b0;
    pkt_data_in  = '0;
    per_rdy_in   = '1;
    dcp_rdy_in   = 1'b1;
    reply_key_in = $urandom;
    for (int i = 0; i < NDC; i++) ctr[i] = $urandom;
    ctr[3] = 32'h0000_00a5;
    for (int i = 0; i < NDC; i++) reg_ctr_in[i*32 +: 32] = ctr[i];

    repeat (3) sync();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pkt_rdy", 80'(pkt_rdy_out), 80'(1));
    chk("rst_per_vld", 80'(per_vld_out), 80'(0));
    chk("rst_dcp_vld", 80'(dcp_vld_out), 80'(0));
    chk("rst_en_cnt_drop", 80'({prx_en_out, prx_cnt_out, prx_drop_out}), 80'(0));
    chk("rst_wr_regs", 80'({prx_addr_out, prx_wdata_out}), 80'(0));
    chk("rst_dcp_data", 80'(dcp_data_out), 80'(0));
    mon_en = 1'b1;
    sync();

    // Two-cycle latency from handshake to channel valid
    for (int c = 0; c < NP; c++) begin
      send(mkpkt(1'b0, 1'b0, chkey(c), $urandom, 1'b1));
      @(negedge clk);
      chk($sformatf("lat1_ch%0d", c), 80'(per_vld_out[c]), 80'(0));
      @(negedge clk);
      chk($sformatf("lat2_ch%0d", c), 80'(per_vld_out[c]), 80'(1));
      sync();
    end

    // Nonexistent channel is dropped with no output
    send(mkpkt(1'b0, 1'b1, chkey(3), $urandom, 1'b1));
    repeat (3) begin
      @(negedge clk);
      chk("bad_ch_no_vld", 80'(per_vld_out), 80'(0));
      sync();
    end

    // Head-of-line blocking behind a stalled channel
    per_rdy_in = 3'b011;
    send(mkpkt(1'b0, 1'b0, chkey(2), $urandom, 1'b1));
    send(mkpkt(1'b0, 1'b0, chkey(2), $urandom, 1'b1));
    p = mkpkt(1'b0, 1'b0, chkey(0), $urandom, 1'b1);
    pkt_data_in = p;
    pkt_vld_in  = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("hol_in_rdy", 80'(pkt_rdy_out), 80'(0));
      chk("hol_ch0_idle", 80'(per_vld_out[0]), 80'(0));
      sync();
    end
    per_rdy_in = '1;
    send(p);
    drain();

    // Register write pulse, address/data and hold
    send(mkpkt(1'b1, 1'b1, 32'h0000_0005, 32'h1234_5678, 1'b1));
    @(negedge clk);
    chk("wr_en_early", 80'(prx_en_out), 80'(0));
    @(negedge clk);
    chk("wr_en_pulse", 80'({prx_en_out, prx_addr_out, prx_wdata_out}), 80'({1'b1, 8'h05, 32'h1234_5678}));
    @(negedge clk);
    chk("wr_en_end_hold", 80'({prx_en_out, prx_addr_out, prx_wdata_out}), 80'({1'b0, 8'h05, 32'h1234_5678}));
    sync();

    // Counter read with stalled reply, second read issued back-to-back
    dcp_rdy_in = 1'b0;
    send(mkpkt(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b1));
    send(mkpkt(1'b1, 1'b0, 32'h0000_0015, 32'h0, 1'b1));
    repeat (5) begin
      @(negedge clk);
      chk("rd_stall_vld", 80'(dcp_vld_out), 80'(1));
      chk("rd_payload_a5", 80'(dcp_data_out[71:40]), 80'(32'ha5));
      chk("rd_odd_parity", 80'(^dcp_data_out), 80'(1));
      sync();
    end
    dcp_rdy_in = 1'b1;
    sync();
    @(negedge clk);
    chk("rd_b2b_vld", 80'(dcp_vld_out), 80'(1));
    chk("rd_b2b_payload", 80'(dcp_data_out[71:40]), 80'(ctr[5]));
    sync();

    // Reads outside the counter range or section return BAD_REG
    send(mkpkt(1'b1, 1'b0, 32'h0000_0018, 32'h0, 1'b1));
    send(mkpkt(1'b1, 1'b0, 32'h0000_0023, 32'h0, 1'b1));
    drain();

`ifdef PKT_RX_PARITY_CHECK_EN
    send(mkpkt(1'b0, 1'b1, chkey(1), $urandom, 1'b0));
    send(mkpkt(1'b0, 1'b1, chkey(1), $urandom, 1'b1));
    drain();
`endif

    // Randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) p = mkpkt(1'b0, 1'($urandom), chkey($urandom_range(0, 3)), $urandom, $urandom_range(0, 4) != 0);
      else if (kind <= 7) p = mkpkt(1'b1, 1'b1, $urandom, $urandom, $urandom_range(0, 4) != 0);
      else begin
        k = $urandom;
        k[7:0] = 8'($urandom_range(0, 2) * 16 + $urandom_range(0, 15));
        p = mkpkt(1'b1, 1'b0, k, $urandom, $urandom_range(0, 4) != 0);
      end
      send(p);
      if ($urandom_range(0, 3) == 0) sync();
    end
    drain();

    // Reset mid-operation flushes everything in flight
    per_rdy_in = '0;
    dcp_rdy_in = 1'b0;
    send(mkpkt(1'b0, 1'b0, chkey(1), $urandom, 1'b1));
    send(mkpkt(1'b1, 1'b0, 32'h0000_0011, 32'h0, 1'b1));
    send(mkpkt(1'b0, 1'b0, chkey(1), $urandom, 1'b1));
    reset = 1'b1;
    exp_ev.delete();
    exp_wr.delete();
    exp_rep.delete();
    for (int i = 0; i < NP; i++) exp_per[i].delete();
    repeat (2) sync();
    reset      = 1'b0;
    per_rdy_in = '1;
    dcp_rdy_in = 1'b1;
    @(negedge clk);
    chk("flush_vld", 80'({per_vld_out, dcp_vld_out, prx_en_out}), 80'(0));
    chk("flush_pkt_rdy", 80'(pkt_rdy_out), 80'(1));
    sync();
    send(mkpkt(1'b0, 1'b0, chkey(2), $urandom, 1'b1));
    drain();

    chk("final_queues_empty", 80'(all_empty()), 80'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
